// File: rtl/jedro_1_test_checker_if.sv
// Configuration and register-file read bus between a test wrapper and jedro_1_test_checker.
// Signal suffixes are from the checker's point of view.
interface jedro_1_test_checker_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 4
);
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic                      cfg_we_i;
  logic [IDX_W-1:0]          cfg_idx_i;
  logic                      cfg_en_i;
  logic [REG_ADDR_WIDTH-1:0] cfg_addr_i;
  logic [DATA_WIDTH-1:0]     cfg_data_i;
  logic [REG_ADDR_WIDTH-1:0] rf_raddr_o;
  logic [DATA_WIDTH-1:0]     rf_rdata_i;

  modport master (
    output cfg_we_i, cfg_idx_i, cfg_en_i, cfg_addr_i, cfg_data_i, rf_rdata_i,
    input  rf_raddr_o
  );

  modport slave (
    input  cfg_we_i, cfg_idx_i, cfg_en_i, cfg_addr_i, cfg_data_i, rf_rdata_i,
    output rf_raddr_o
  );
endinterface

// File: rtl/jedro_1_test_checker.sv
// End-of-test checker for jedro_1: RUN until illegal instruction or budget, DRAIN, then walk the check table.
// Optional macro JEDRO_1_CHECKER_TIMEOUT_FAIL_EN makes a budget timeout force pass_o low.
module jedro_1_test_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 4,
  parameter int MAX_CYCLES     = 32,
  parameter int DRAIN_CYCLES   = 3,
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int ERR_W = $clog2(NUM_CHECKS + 1),
  localparam int CYC_W = $clog2(MAX_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  illegal_instr_i,
  jedro_1_test_checker_if.slave bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ERR_W-1:0]      err_count_o,
  output logic [IDX_W-1:0]      fail_idx_o,
  output logic [DATA_WIDTH-1:0] fail_value_o,
  output logic [CYC_W-1:0]      cycles_o
);
  localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CHECK, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [CYC_W-1:0]          cycles_q, cycles_d;
  logic [DRN_W-1:0]          drain_q, drain_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [ERR_W-1:0]          err_q, err_d;
  logic [IDX_W-1:0]          fail_idx_q, fail_idx_d;
  logic [DATA_WIDTH-1:0]     fail_val_q, fail_val_d;
  logic                      timeout_q, timeout_d;
  logic                      pass_q, pass_d;
  logic                      en_q   [NUM_CHECKS];
  logic                      en_d   [NUM_CHECKS];
  logic [REG_ADDR_WIDTH-1:0] addr_q [NUM_CHECKS];
  logic [REG_ADDR_WIDTH-1:0] addr_d [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     data_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     data_d [NUM_CHECKS];

  logic mismatch;
  logic idle_like;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  // Compare the combinational register-file read against the current entry.
  assign mismatch  = en_q[idx_q] && (bus.rf_rdata_i != data_q[idx_q]);

  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    drain_d    = drain_q;
    idx_d      = idx_q;
    err_d      = err_q;
    fail_idx_d = fail_idx_q;
    fail_val_d = fail_val_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    en_d       = en_q;
    addr_d     = addr_q;
    data_d     = data_q;

    if (idle_like && bus.cfg_we_i && (int'(bus.cfg_idx_i) < NUM_CHECKS)) begin
      en_d[bus.cfg_idx_i]   = bus.cfg_en_i;
      addr_d[bus.cfg_idx_i] = bus.cfg_addr_i;
      data_d[bus.cfg_idx_i] = bus.cfg_data_i;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_RUN;
          cycles_d   = '0;
          drain_d    = '0;
          idx_d      = '0;
          err_d      = '0;
          fail_idx_d = '0;
          fail_val_d = '0;
          timeout_d  = 1'b0;
          pass_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (cycles_q < CYC_W'(MAX_CYCLES)) cycles_d = cycles_q + 1'b1;
        // Illegal instruction takes priority over the budget in the same cycle.
        if (illegal_instr_i || (cycles_q == CYC_W'(MAX_CYCLES - 1))) begin
          timeout_d = !illegal_instr_i;
          drain_d   = '0;
          idx_d     = '0;
          state_d   = (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (int'(drain_q) >= DRAIN_CYCLES - 1) state_d = S_CHECK;
        else                                   drain_d = drain_q + 1'b1;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q < ERR_W'(NUM_CHECKS)) err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fail_idx_d = idx_q;
            fail_val_d = bus.rf_rdata_i;
          end
        end
        if (int'(idx_q) == NUM_CHECKS - 1) begin
          state_d = S_DONE;
`ifdef JEDRO_1_CHECKER_TIMEOUT_FAIL_EN
          pass_d  = (err_d == '0) && !timeout_q;
`else
          pass_d  = (err_d == '0);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cycles_q   <= '0;
      drain_q    <= '0;
      idx_q      <= '0;
      err_q      <= '0;
      fail_idx_q <= '0;
      fail_val_q <= '0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        en_q[i]   <= 1'b0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      drain_q    <= drain_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      fail_idx_q <= fail_idx_d;
      fail_val_q <= fail_val_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.rf_raddr_o = (state_q == S_CHECK) ? addr_q[idx_q] : '0;
  assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_CHECK);
  assign done_o         = (state_q == S_DONE);
  assign pass_o         = pass_q;
  assign timeout_o      = timeout_q;
  assign err_count_o    = err_q;
  assign fail_idx_o     = fail_idx_q;
  assign fail_value_o   = fail_val_q;
  assign cycles_o       = cycles_q;
endmodule

// File: tb/tb_jedro_1_test_checker.sv
// Directed bench for jedro_1_test_checker with default parameters (4 checks, 32-cycle budget, 3 drain cycles).
module tb_jedro_1_test_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        illegal;
  logic        busy, done, pass, timeout;
  logic [2:0]  err_count;
  logic [1:0]  fail_idx;
  logic [31:0] fail_value;
  logic [5:0]  cycles;
  logic [31:0] rf [32];

  int tests_run    = 0;
  int tests_failed = 0;

  jedro_1_test_checker_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_CHECKS(4)) bus ();

  assign bus.rf_rdata_i = rf[bus.rf_raddr_o];

  jedro_1_test_checker #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_CHECKS(4), .MAX_CYCLES(32), .DRAIN_CYCLES(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .illegal_instr_i(illegal), .bus(bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout), .err_count_o(err_count),
    .fail_idx_o(fail_idx), .fail_value_o(fail_value), .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  // All stimulus tasks start and end just after a falling edge.
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; illegal = 1'b0;
    bus.cfg_we_i = 1'b0; bus.cfg_idx_i = '0; bus.cfg_en_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_data_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_entry(input logic [1:0] idx, input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.cfg_we_i = 1'b1; bus.cfg_idx_i = idx; bus.cfg_en_i = en; bus.cfg_addr_i = a; bus.cfg_data_i = d;
    @(negedge clk);
    bus.cfg_we_i = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_illegal();
    illegal = 1'b1;
    @(negedge clk);
    illegal = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0b expected 0", done); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL reset_pass: got %0b expected 0", pass); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
    tests_run++; if (err_count !== 3'd0) begin tests_failed++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    tests_run++; if (cycles !== 6'd0) begin tests_failed++; $display("FAIL reset_cycles: got %0d expected 0", cycles); end
    tests_run++; if (bus.rf_raddr_o !== 5'd0) begin tests_failed++; $display("FAIL reset_raddr: got %0d expected 0", bus.rf_raddr_o); end
  endtask

  task automatic test_sltu_pass();
    int n;
    do_reset();
    rf[1] = 32'd1; rf[2] = 32'd0;
    write_entry(2'd0, 1'b1, 5'd1, 32'd1);
    write_entry(2'd1, 1'b1, 5'd2, 32'd0);
    start_pulse();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL sltu_busy: got %0b expected 1", busy); end
    tests_run++; if (cycles !== 6'd0) begin tests_failed++; $display("FAIL sltu_cycles0: got %0d expected 0", cycles); end
    repeat (9) @(negedge clk);
    tests_run++; if (bus.rf_raddr_o !== 5'd0) begin tests_failed++; $display("FAIL sltu_raddr_run: got %0d expected 0", bus.rf_raddr_o); end
    pulse_illegal();
    tests_run++; if (cycles !== 6'd10) begin tests_failed++; $display("FAIL sltu_cycles: got %0d expected 10", cycles); end
    wait_done(50, n);
    tests_run++; if (n !== 7) begin tests_failed++; $display("FAIL sltu_latency: got %0d expected 7", n); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL sltu_pass: got %0b expected 1", pass); end
    tests_run++; if (err_count !== 3'd0) begin tests_failed++; $display("FAIL sltu_err: got %0d expected 0", err_count); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL sltu_timeout: got %0b expected 0", timeout); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL sltu_busy_done: got %0b expected 0", busy); end
  endtask

  task automatic test_mismatch();
    int n;
    do_reset();
    rf[1] = 32'd0;
    write_entry(2'd0, 1'b1, 5'd1, 32'd1);
    start_pulse();
    repeat (2) @(negedge clk);
    pulse_illegal();
    tests_run++; if (cycles !== 6'd3) begin tests_failed++; $display("FAIL mis_cycles: got %0d expected 3", cycles); end
    wait_done(50, n);
    tests_run++; if (n !== 7) begin tests_failed++; $display("FAIL mis_latency: got %0d expected 7", n); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL mis_pass: got %0b expected 0", pass); end
    tests_run++; if (err_count !== 3'd1) begin tests_failed++; $display("FAIL mis_err: got %0d expected 1", err_count); end
    tests_run++; if (fail_idx !== 2'd0) begin tests_failed++; $display("FAIL mis_fail_idx: got %0d expected 0", fail_idx); end
    tests_run++; if (fail_value !== 32'd0) begin tests_failed++; $display("FAIL mis_fail_value: got %0h expected 0", fail_value); end
  endtask

  task automatic test_timeout();
    int n;
    logic exp_pass;
`ifdef JEDRO_1_CHECKER_TIMEOUT_FAIL_EN
    exp_pass = 1'b0;
`else
    exp_pass = 1'b1;
`endif
    do_reset();
    rf[1] = 32'd1;
    write_entry(2'd0, 1'b1, 5'd1, 32'd1);
    start_pulse();
    wait_done(100, n);
    tests_run++; if (n !== 39) begin tests_failed++; $display("FAIL to_latency: got %0d expected 39", n); end
    tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL to_timeout: got %0b expected 1", timeout); end
    tests_run++; if (cycles !== 6'd32) begin tests_failed++; $display("FAIL to_cycles: got %0d expected 32", cycles); end
    tests_run++; if (err_count !== 3'd0) begin tests_failed++; $display("FAIL to_err: got %0d expected 0", err_count); end
    tests_run++; if (pass !== exp_pass) begin tests_failed++; $display("FAIL to_pass: got %0b expected %0b", pass, exp_pass); end
  endtask

  task automatic test_multi_mismatch();
    int n;
    do_reset();
    rf[3] = 32'h33; rf[4] = 32'h55; rf[5] = 32'h99; rf[6] = 32'h66;
    write_entry(2'd0, 1'b1, 5'd3, 32'h33);
    write_entry(2'd1, 1'b1, 5'd4, 32'hAA);
    write_entry(2'd2, 1'b0, 5'd5, 32'h01);
    write_entry(2'd3, 1'b1, 5'd6, 32'h77);
    start_pulse();
    pulse_illegal();
    repeat (3) @(negedge clk);
    tests_run++; if (bus.rf_raddr_o !== 5'd3) begin tests_failed++; $display("FAIL multi_raddr: got %0d expected 3", bus.rf_raddr_o); end
    wait_done(50, n);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL multi_latency: got %0d expected 4", n); end
    tests_run++; if (err_count !== 3'd2) begin tests_failed++; $display("FAIL multi_err: got %0d expected 2", err_count); end
    tests_run++; if (fail_idx !== 2'd1) begin tests_failed++; $display("FAIL multi_fail_idx: got %0d expected 1", fail_idx); end
    tests_run++; if (fail_value !== 32'h55) begin tests_failed++; $display("FAIL multi_fail_value: got %0h expected 55", fail_value); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL multi_pass: got %0b expected 0", pass); end
  endtask

  task automatic test_rst_in_drain();
    int n;
    do_reset();
    rf[1] = 32'd0;
    write_entry(2'd0, 1'b1, 5'd1, 32'hDEAD);
    start_pulse();
    repeat (3) @(negedge clk);
    start_pulse();
    tests_run++; if (cycles !== 6'd4) begin tests_failed++; $display("FAIL ign_start_cycles: got %0d expected 4", cycles); end
    pulse_illegal();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL drain_busy: got %0b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL abort_done: got %0b expected 0", done); end
    tests_run++; if (cycles !== 6'd0) begin tests_failed++; $display("FAIL abort_cycles: got %0d expected 0", cycles); end
    start_pulse();
    pulse_illegal();
    wait_done(50, n);
    tests_run++; if (err_count !== 3'd0) begin tests_failed++; $display("FAIL cleared_err: got %0d expected 0", err_count); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL cleared_pass: got %0b expected 1", pass); end
  endtask

  task automatic test_cfg_in_run();
    int n;
    do_reset();
    rf[1] = 32'd5;
    write_entry(2'd0, 1'b1, 5'd1, 32'd5);
    start_pulse();
    write_entry(2'd0, 1'b1, 5'd1, 32'd9);
    repeat (30) @(negedge clk);
    pulse_illegal();
    tests_run++; if (cycles !== 6'd32) begin tests_failed++; $display("FAIL tie_cycles: got %0d expected 32", cycles); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL tie_timeout: got %0b expected 0", timeout); end
    wait_done(50, n);
    tests_run++; if (n !== 7) begin tests_failed++; $display("FAIL tie_latency: got %0d expected 7", n); end
    tests_run++; if (err_count !== 3'd0) begin tests_failed++; $display("FAIL cfg_run_err: got %0d expected 0", err_count); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL cfg_run_pass: got %0b expected 1", pass); end
  endtask

  task automatic test_back_to_back();
    int n;
    rf[1] = 32'd7;
    start_pulse();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL b2b_done: got %0b expected 0", done); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL b2b_pass_clr: got %0b expected 0", pass); end
    pulse_illegal();
    wait_done(50, n);
    tests_run++; if (n !== 7) begin tests_failed++; $display("FAIL b2b_latency: got %0d expected 7", n); end
    tests_run++; if (cycles !== 6'd1) begin tests_failed++; $display("FAIL b2b_cycles: got %0d expected 1", cycles); end
    tests_run++; if (err_count !== 3'd1) begin tests_failed++; $display("FAIL b2b_err: got %0d expected 1", err_count); end
    tests_run++; if (fail_value !== 32'd7) begin tests_failed++; $display("FAIL b2b_fail_value: got %0h expected 7", fail_value); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    test_reset();
    test_sltu_pass();
    test_mismatch();
    test_timeout();
    test_multi_mismatch();
    test_rst_in_drain();
    test_cfg_in_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
